// File: rtl/image_stats.sv
// Per-channel frame statistics engine: accumulates min/max/sum and a pixel count
// between start and the last pixel, then publishes the results with a done pulse.
module image_stats #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned CH_W   = 4,
    parameter int unsigned CNT_W  = 17,
    localparam int unsigned SUM_W = CH_W + CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      pix_vld,
    input  logic                      pix_last,
    input  logic [NUM_CH*CH_W-1:0]    pixel_in,
    output logic                      busy,
    output logic                      done,
    output logic [NUM_CH*CH_W-1:0]    min_out,
    output logic [NUM_CH*CH_W-1:0]    max_out,
    output logic [NUM_CH*SUM_W-1:0]   sum_out,
    output logic [CNT_W-1:0]          count_out,
    output logic                      ovf
);

    localparam int unsigned PIX_W  = NUM_CH * CH_W;
    localparam int unsigned SUMS_W = NUM_CH * SUM_W;

    typedef enum logic {IDLE, ACCUM} state_e;

    state_e state_q, state_d;

    logic [PIX_W-1:0]  run_min_q, run_min_d;
    logic [PIX_W-1:0]  run_max_q, run_max_d;
    logic [SUMS_W-1:0] run_sum_q, run_sum_d;
    logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
    logic              run_ovf_q, run_ovf_d;

    logic [PIX_W-1:0]  min_q, min_d;
    logic [PIX_W-1:0]  max_q, max_d;
    logic [SUMS_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;

    logic accept_c;
    logic cnt_sat_c;

    assign accept_c  = (state_q == ACCUM) && pix_vld;
    assign cnt_sat_c = &run_cnt_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start always (re)enters ACCUM and outranks a final pixel
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACCUM;
            ACCUM:   if (!start && pix_vld && pix_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy      = (state_q == ACCUM);
        done      = done_q;
        min_out   = min_q;
        max_out   = max_q;
        sum_out   = sum_q;
        count_out = cnt_q;
        ovf       = ovf_q;
    end

    // Running accumulation and frame-end publish
    always_comb begin
        run_min_d = run_min_q;
        run_max_d = run_max_q;
        run_sum_d = run_sum_q;
        run_cnt_d = run_cnt_q;
        run_ovf_d = run_ovf_q;
        min_d     = min_q;
        max_d     = max_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;

        if (start) begin
            run_min_d = '1;
            run_max_d = '0;
            run_sum_d = '0;
            run_cnt_d = '0;
            run_ovf_d = 1'b0;
        end else if (accept_c) begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                if (pixel_in[c*CH_W +: CH_W] < run_min_q[c*CH_W +: CH_W])
                    run_min_d[c*CH_W +: CH_W] = pixel_in[c*CH_W +: CH_W];
                if (pixel_in[c*CH_W +: CH_W] > run_max_q[c*CH_W +: CH_W])
                    run_max_d[c*CH_W +: CH_W] = pixel_in[c*CH_W +: CH_W];
                if (!cnt_sat_c)
                    run_sum_d[c*SUM_W +: SUM_W] = run_sum_q[c*SUM_W +: SUM_W]
                                                + SUM_W'(pixel_in[c*CH_W +: CH_W]);
            end
            // Once the count saturates, sum and count freeze and the overflow flag sticks
            if (cnt_sat_c) run_ovf_d = 1'b1;
            else           run_cnt_d = run_cnt_q + CNT_W'(1);

            if (pix_last) begin
                min_d  = run_min_d;
                max_d  = run_max_d;
                sum_d  = run_sum_d;
                cnt_d  = run_cnt_d;
                ovf_d  = run_ovf_d;
                done_d = 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_min_q <= '1;
            run_max_q <= '0;
            run_sum_q <= '0;
            run_cnt_q <= '0;
            run_ovf_q <= 1'b0;
            min_q     <= '1;
            max_q     <= '0;
            sum_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            run_min_q <= run_min_d;
            run_max_q <= run_max_d;
            run_sum_q <= run_sum_d;
            run_cnt_q <= run_cnt_d;
            run_ovf_q <= run_ovf_d;
            min_q     <= min_d;
            max_q     <= max_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_image_stats.sv
// Bench for image_stats: a default-width instance and a 3-bit-counter instance share
// stimulus; a frame-level reference model checks both every cycle.
module tb_image_stats;

    localparam int unsigned NUM_CH    = 3;
    localparam int unsigned CH_W      = 4;
    localparam int unsigned CNT_W     = 17;
    localparam int unsigned SAT_CNT_W = 3;
    localparam int unsigned PIX_W     = NUM_CH * CH_W;
    localparam int unsigned SUM_W     = CH_W + CNT_W;
    localparam int unsigned SAT_SUM_W = CH_W + SAT_CNT_W;

    logic clk = 1'b0;
    logic rst, start, pix_vld, pix_last;
    logic [PIX_W-1:0] pixel_in;

    logic                     busy0, done0, ovf0;
    logic [PIX_W-1:0]         min0, max0;
    logic [NUM_CH*SUM_W-1:0]  sum0;
    logic [CNT_W-1:0]         cnt0;

    logic                        busy1, done1, ovf1;
    logic [PIX_W-1:0]            min1, max1;
    logic [NUM_CH*SAT_SUM_W-1:0] sum1;
    logic [SAT_CNT_W-1:0]        cnt1;

    image_stats #(.NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst), .start(start), .pix_vld(pix_vld), .pix_last(pix_last),
        .pixel_in(pixel_in), .busy(busy0), .done(done0), .min_out(min0), .max_out(max0),
        .sum_out(sum0), .count_out(cnt0), .ovf(ovf0)
    );

    image_stats #(.NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(SAT_CNT_W)) u_sat (
        .clk(clk), .rst(rst), .start(start), .pix_vld(pix_vld), .pix_last(pix_last),
        .pixel_in(pixel_in), .busy(busy1), .done(done1), .min_out(min1), .max_out(max1),
        .sum_out(sum1), .count_out(cnt1), .ovf(ovf1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: frame pixels kept in a queue, statistics derived at frame end
    bit               m_busy;
    bit               m_done;
    logic [PIX_W-1:0] pq[$];
    logic [63:0]      e_min[2], e_max[2], e_sum[2], e_cnt[2];
    bit               e_ovf[2];
    int unsigned      cap[2];
    int unsigned      sw[2];

    task automatic model_reset();
        m_busy = 1'b0;
        m_done = 1'b0;
        pq.delete();
        for (int i = 0; i < 2; i++) begin
            e_min[i] = (64'd1 << PIX_W) - 64'd1;
            e_max[i] = '0;
            e_sum[i] = '0;
            e_cnt[i] = '0;
            e_ovf[i] = 1'b0;
        end
    endtask

    task automatic model_finish();
        for (int i = 0; i < 2; i++) begin
            int unsigned n = pq.size();
            int unsigned k = (n < cap[i]) ? n : cap[i];
            e_min[i] = '0;
            e_max[i] = '0;
            e_sum[i] = '0;
            for (int c = 0; c < int'(NUM_CH); c++) begin
                int unsigned mn = 15, mx = 0, s = 0;
                for (int j = 0; j < int'(n); j++) begin
                    int unsigned v = (int'(pq[j]) >> (c * CH_W)) & 15;
                    if (v < mn) mn = v;
                    if (v > mx) mx = v;
                    if (j < int'(k)) s += v;
                end
                e_min[i] |= 64'(mn) << (c * CH_W);
                e_max[i] |= 64'(mx) << (c * CH_W);
                e_sum[i] |= 64'(s) << (c * sw[i]);
            end
            e_cnt[i] = 64'(k);
            e_ovf[i] = (n > cap[i]);
        end
    endtask

    task automatic model_edge(input bit st, input bit vld, input bit last, input logic [PIX_W-1:0] pix);
        m_done = 1'b0;
        if (st) begin
            m_busy = 1'b1;
            pq.delete();
        end else if (m_busy && vld) begin
            pq.push_back(pix);
            if (last) begin
                model_finish();
                m_done = 1'b1;
                m_busy = 1'b0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " busy0"}, 64'(busy0), 64'(m_busy));
        chk({tag, " done0"}, 64'(done0), 64'(m_done));
        chk({tag, " min0"},  64'(min0),  e_min[0]);
        chk({tag, " max0"},  64'(max0),  e_max[0]);
        chk({tag, " sum0"},  64'(sum0),  e_sum[0]);
        chk({tag, " cnt0"},  64'(cnt0),  e_cnt[0]);
        chk({tag, " ovf0"},  64'(ovf0),  64'(e_ovf[0]));
        chk({tag, " busy1"}, 64'(busy1), 64'(m_busy));
        chk({tag, " done1"}, 64'(done1), 64'(m_done));
        chk({tag, " min1"},  64'(min1),  e_min[1]);
        chk({tag, " max1"},  64'(max1),  e_max[1]);
        chk({tag, " sum1"},  64'(sum1),  e_sum[1]);
        chk({tag, " cnt1"},  64'(cnt1),  e_cnt[1]);
        chk({tag, " ovf1"},  64'(ovf1),  64'(e_ovf[1]));
    endtask

    task automatic step(input string tag, input bit st, input bit vld, input bit last,
                        input logic [PIX_W-1:0] pix);
        start    = st;
        pix_vld  = vld;
        pix_last = last;
        pixel_in = pix;
        @(posedge clk);
        model_edge(st, vld, last, pix);
        #1;
        check_all(tag);
    endtask

    typedef struct {
        bit               st, vld, last;
        logic [PIX_W-1:0] pix;
        bit               busy, done;
        logic [PIX_W-1:0] mn, mx;
        int unsigned      cnt;
    } vec_t;

    vec_t vt[$];

    task automatic add(input bit st, input bit vld, input bit last, input logic [PIX_W-1:0] pix,
                       input bit b, input bit d, input logic [PIX_W-1:0] mn,
                       input logic [PIX_W-1:0] mx, input int unsigned cnt);
        vec_t v;
        v.st = st; v.vld = vld; v.last = last; v.pix = pix;
        v.busy = b; v.done = d; v.mn = mn; v.mx = mx; v.cnt = cnt;
        vt.push_back(v);
    endtask

    initial begin
        cap[0] = (1 << CNT_W) - 1;
        cap[1] = (1 << SAT_CNT_W) - 1;
        sw[0]  = SUM_W;
        sw[1]  = SAT_SUM_W;

        // Idle pixels ignored
        add(0, 1, 0, 12'h123, 0, 0, 12'hFFF, 12'h000, 0);
        add(0, 1, 1, 12'h123, 0, 0, 12'hFFF, 12'h000, 0);
        // Three-pixel frame
        add(1, 0, 0, 12'h000, 1, 0, 12'hFFF, 12'h000, 0);
        add(0, 1, 0, 12'h3A5, 1, 0, 12'hFFF, 12'h000, 0);
        add(0, 1, 0, 12'h1F7, 1, 0, 12'hFFF, 12'h000, 0);
        add(0, 1, 1, 12'hC02, 0, 1, 12'h102, 12'hCF7, 3);
        add(0, 0, 0, 12'h000, 0, 0, 12'h102, 12'hCF7, 3);
        // Single-pixel frame
        add(1, 0, 0, 12'h000, 1, 0, 12'h102, 12'hCF7, 3);
        add(0, 1, 1, 12'h7E1, 0, 1, 12'h7E1, 12'h7E1, 1);
        add(0, 0, 0, 12'h000, 0, 0, 12'h7E1, 12'h7E1, 1);
        // Abort and restart
        add(1, 0, 0, 12'h000, 1, 0, 12'h7E1, 12'h7E1, 1);
        add(0, 1, 0, 12'h000, 1, 0, 12'h7E1, 12'h7E1, 1);
        add(0, 1, 0, 12'hFFF, 1, 0, 12'h7E1, 12'h7E1, 1);
        add(1, 0, 0, 12'h000, 1, 0, 12'h7E1, 12'h7E1, 1);
        add(0, 1, 1, 12'h555, 0, 1, 12'h555, 12'h555, 1);
        // start colliding with a last pixel in ACCUM
        add(1, 0, 0, 12'h000, 1, 0, 12'h555, 12'h555, 1);
        add(1, 1, 1, 12'h000, 1, 0, 12'h555, 12'h555, 1);
        add(0, 1, 1, 12'h888, 0, 1, 12'h888, 12'h888, 1);
        // pix_last without pix_vld
        add(1, 0, 0, 12'h000, 1, 0, 12'h888, 12'h888, 1);
        add(0, 0, 1, 12'hFFF, 1, 0, 12'h888, 12'h888, 1);
        add(0, 1, 1, 12'h444, 0, 1, 12'h444, 12'h444, 1);
        // start with a pixel in IDLE: frame starts empty
        add(1, 1, 1, 12'h000, 1, 0, 12'h444, 12'h444, 1);
        add(0, 1, 1, 12'hAAA, 0, 1, 12'hAAA, 12'hAAA, 1);

        rst = 1'b1; start = 1'b0; pix_vld = 1'b0; pix_last = 1'b0; pixel_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            step($sformatf("vec%0d", i), vt[i].st, vt[i].vld, vt[i].last, vt[i].pix);
            chk($sformatf("vec%0d busy", i), 64'(busy0), 64'(vt[i].busy));
            chk($sformatf("vec%0d done", i), 64'(done0), 64'(vt[i].done));
            chk($sformatf("vec%0d min", i),  64'(min0),  64'(vt[i].mn));
            chk($sformatf("vec%0d max", i),  64'(max0),  64'(vt[i].mx));
            chk($sformatf("vec%0d cnt", i),  64'(cnt0),  64'(vt[i].cnt));
        end

        // Nine pixels into the 3-bit counter instance
        step("sat_start", 1, 0, 0, 12'h000);
        for (int i = 0; i < 8; i++) step($sformatf("sat%0d", i), 0, 1, 0, 12'h111);
        step("sat_last", 0, 1, 1, 12'h111);
        chk("sat cnt1", 64'(cnt1), 64'd7);
        chk("sat sum1 ch0", 64'(sum1[SAT_SUM_W-1:0]), 64'd7);
        chk("sat ovf1", 64'(ovf1), 64'd1);
        chk("sat cnt0", 64'(cnt0), 64'd9);
        chk("sat sum0 ch0", 64'(sum0[SUM_W-1:0]), 64'd9);
        chk("sat ovf0", 64'(ovf0), 64'd0);

        // Async reset mid-frame, asserted between edges
        step("rst_start", 1, 0, 0, 12'h000);
        step("rst_p0", 0, 1, 0, 12'h5A5);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst min", 64'(min0), 64'hFFF);
        @(negedge clk);
        rst = 1'b0;

        // Randomised frames, including aborts, collisions and saturation
        for (int i = 0; i < 600; i++) begin
            bit st, vld, last;
            st   = ($urandom_range(0, 19) == 0);
            vld  = ($urandom_range(0, 3) != 0);
            last = ($urandom_range(0, 9) == 0);
            step($sformatf("rnd%0d", i), st, vld, last, PIX_W'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/image_stats.md
Name: image_stats

Overview:
- Parametrised per-channel frame statistics engine on the image co-processor pixel stream.
- For each frame it accumulates per-channel min, max and sum, plus a pixel count.
- At frame end it latches the results into output registers and pulses done; software/CPU reads them for contrast stretch and mean computation.
- Frame boundaries are explicit via start and pix_last, not inferred from func decoding.

Parameters:
- NUM_CH, 3, number of colour channels packed in a pixel.
- CH_W, 4, bits per channel.
- CNT_W, 17, pixel counter width (covers 320x240 = 76800).
- SUM_W, CH_W+CNT_W, per-channel sum width (derived; do not override).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  single-cycle pulse: begin a new frame
- pix_vld  in  1  pixel_in valid this cycle
- pix_last  in  1  qualifies pix_vld: this is the frame's final pixel
- pixel_in  in  NUM_CH*CH_W  packed pixel; channel c at [c*CH_W +: CH_W]
- busy  out  1  high while in ACCUM
- done  out  1  one-cycle pulse when results are updated
- min_out  out  NUM_CH*CH_W  per-channel minimum of last completed frame
- max_out  out  NUM_CH*CH_W  per-channel maximum of last completed frame
- sum_out  out  NUM_CH*SUM_W  per-channel sum of last completed frame
- count_out  out  CNT_W  pixels in last completed frame
- ovf  out  1  last completed frame hit counter saturation

Behaviour:
- Clock is clk. Reset is rst: asynchronous, active-high.
- Reset values:
  - FSM state = IDLE; busy = 0; done = 0.
  - min_out = all ones; max_out = 0; sum_out = 0; count_out = 0; ovf = 0.
  - Running registers: same values as the corresponding outputs.
- FSM has two states, IDLE and ACCUM.
- IDLE:
  - pix_vld and pix_last are ignored.
  - start -> ACCUM. On the same edge, running registers clear: run_min = all ones, run_max = 0, run_sum = 0, run_cnt = 0, run_ovf = 0.
- ACCUM (busy = 1):
  - Each cycle with pix_vld = 1, per channel c:
    - run_min[c] = min(run_min[c], ch).
    - run_max[c] = max(run_max[c], ch).
    - run_sum[c] += ch (zero-extended, unsigned).
  - run_cnt += 1 on each accepted pixel.
  - All channels update independently in the same cycle. Comparisons are unsigned.
- Frame end: pix_vld & pix_last accepts that pixel, then at the next edge:
  - Outputs load the final running values, including that pixel.
  - done = 1 for exactly one cycle.
  - State -> IDLE.
  - Latency: results and done are visible one cycle after the last pixel's edge.
- Outputs hold their values until the next done. They are never partially updated mid-frame.
- pix_last without pix_vld has no effect.
- start during ACCUM: abort and restart. Running registers clear and state stays ACCUM. Outputs are unchanged and no done pulse is issued.
- start and pix_vld in the same ACCUM cycle: start wins and the pixel is discarded, including when pix_last = 1.
- start and a pixel arriving in IDLE in the same cycle: the pixel is discarded, and the frame starts empty.
- Counter saturation: when run_cnt = all ones, further pixels still update min/max. Sum and count hold, and run_ovf = 1 (sticky until the next start). Sums cannot overflow before the count saturates because SUM_W = CH_W + CNT_W.
- rst mid-frame: immediate return to reset values; any partial frame is lost.
- No backpressure: every pix_vld in ACCUM is consumed.

Test Plan:
- Reset, then idle: pix_vld pulses with pixel_in = 0x123 while IDLE -> busy = 0, no done, min_out = 0xFFF, max_out = 0x000, count_out = 0.
- Frame of pixels 0x3A5, 0x1F7, 0xC02 (last) -> done one cycle after 0xC02; min_out = 0x102, max_out = 0xCF7, sum_out ch0 = 14, ch1 = 25, ch2 = 16; count_out = 3; ovf = 0.
- Single-pixel frame, start then 0x7E1 with pix_last in the next cycle -> min_out = max_out = 0x7E1, count_out = 1, done high exactly 1 cycle.
- Abort: start, pixels 0x000 and 0xFFF, start again, then 0x555 (last) -> min_out = max_out = 0x555, count_out = 1, one done total; previous outputs held until that done.
- Collision: in ACCUM, start coincident with pix_vld = 1, pix_last = 1, pixel 0x000 -> no done, pixel discarded, busy stays 1. Then 0x888 (last) -> min_out = 0x888.
- Saturation with CNT_W = 3: start, then 9 pixels of 0x111 with the 9th last -> count_out = 7, ch0 sum = 7, ovf = 1. Async rst mid-frame -> all outputs return to reset values within the cycle.
